// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, arbiter state encoding and the standard initial hash value.
// Latency: none, because this file holds only declarations.
// Backpressure: none.
package sha256_pkg;

   typedef logic [255:0] hash_t;    // {h0..h7}, h0 in the MSBs
   typedef logic [511:0] block_t;   // {w0..w15}, w0 in the MSBs

   typedef enum logic [2:0] {
      ARB_IDLE,
      ARB_GRANT,
      ARB_START,
      ARB_WAIT,
      ARB_RESP
   } arb_state_e;

   // Initial hash value (first 32 bits of the fractional parts of sqrt of the first 8 primes)
   localparam logic [31:0] H0 [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   // H0 packed into a chaining value with h0 in the MSBs
   function automatic hash_t h0_hash();
      hash_t h;
      h = '0;
      for (int i = 0; i < 8; i++) begin
         h[255 - 32*i -: 32] = H0[i];
      end
      return h;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping modulo N.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides when the grant is consumed and advances ptr.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          found
);

   // Scan N positions starting at ptr; the first requester seen wins
   always_comb begin
      int          cand;
      logic [IW-1:0] cand_idx;
      gnt      = '0;
      idx      = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int i = 0; i < N; i++) begin
         cand     = (int'(ptr) + i) % N;
         cand_idx = IW'(cand);
         if (!found && req[cand_idx]) begin
            found         = 1'b1;
            gnt[cand_idx] = 1'b1;
            idx           = cand_idx;
         end
      end
   end

endmodule

// File: rtl/sha256_core_arbiter.sv
// Round-robin sequencer sharing one SHA-256 compression core among NUM_REQ requesters.
// Latency: req_ready 1 cycle after a request seen in IDLE, core_start 1 cycle later, rsp_valid 1 cycle after core_done.
// Backpressure: one job in flight; requesters hold req_valid and data until their req_ready pulse. Watchdog: SHA_ARB_WDOG_EN.
module sha256_core_arbiter
   import sha256_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT_CYC = 128
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*256-1:0] req_hin,
   input  logic [NUM_REQ*512-1:0] req_block,
   output logic                   core_start,
   output logic [255:0]           core_hin,
   output logic [511:0]           core_block,
   input  logic                   core_done,
   input  logic [255:0]           core_hout,
   output logic                   core_abort,
   output logic [NUM_REQ-1:0]     rsp_valid,
   output logic [255:0]           rsp_hash,
   output logic                   rsp_err,
   output logic                   busy
);

   localparam int IW = $clog2(NUM_REQ);

   // Reject configurations the winner index and watchdog counter are not sized for
   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
      $error("sha256_core_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC at least 1");
   end

   arb_state_e    state_q, state_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IW-1:0] win_q, win_d;
   hash_t         hin_q, hin_d;
   block_t        block_q, block_d;
   hash_t         hash_q, hash_d;

   logic [NUM_REQ-1:0] arb_gnt;
   logic [IW-1:0]      arb_idx;
   logic               arb_found;
   logic [IW-1:0]      ptr_next;
   hash_t              sel_hin;
   block_t             sel_block;

`ifdef SHA_ARB_WDOG_EN
   localparam int              CW      = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT_CYC);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
`endif

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_rr (
      .req   (req_valid),
      .ptr   (rr_ptr_q),
      .gnt   (arb_gnt),
      .idx   (arb_idx),
      .found (arb_found)
   );

   // One-hot AND-OR mux of the winning requester's chaining value and block
   always_comb begin
      sel_hin   = '0;
      sel_block = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_gnt[i]) begin
            sel_hin   = sel_hin   | req_hin[i*256 +: 256];
            sel_block = sel_block | req_block[i*512 +: 512];
         end
      end
   end

   // Round-robin pointer moves to the slot just after the winner
   always_comb begin
      ptr_next = '0;
      if (arb_idx != IW'(NUM_REQ - 1)) begin
         ptr_next = arb_idx + 1'b1;
      end
   end

   // Next-state and pulse outputs for the job sequencer
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      win_d      = win_q;
      hin_d      = hin_q;
      block_d    = block_q;
      hash_d     = hash_q;
      req_ready  = '0;
      core_start = 1'b0;
      rsp_valid  = '0;
`ifdef SHA_ARB_WDOG_EN
      cnt_d      = cnt_q;
      err_d      = err_q;
      core_abort = 1'b0;
`endif

      case (state_q)
         ARB_IDLE: begin
            if (|req_valid) begin
               state_d = ARB_GRANT;
            end
         end

         ARB_GRANT: begin
            // Request may have been withdrawn since IDLE; drop back without a pulse
            if (arb_found) begin
               req_ready = arb_gnt;
               win_d     = arb_idx;
               hin_d     = sel_hin;
               block_d   = sel_block;
               rr_ptr_d  = ptr_next;
               state_d   = ARB_START;
            end else begin
               state_d   = ARB_IDLE;
            end
         end

         ARB_START: begin
            core_start = 1'b1;
            state_d    = ARB_WAIT;
`ifdef SHA_ARB_WDOG_EN
            cnt_d      = '0;
`endif
         end

         ARB_WAIT: begin
            // A completion in the timeout cycle takes priority over the watchdog
            if (core_done) begin
               hash_d  = core_hout;
               state_d = ARB_RESP;
`ifdef SHA_ARB_WDOG_EN
               err_d   = 1'b0;
            end else if (cnt_q == CNT_MAX) begin
               core_abort = 1'b1;
               err_d      = 1'b1;
               hash_d     = '0;
               state_d    = ARB_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end

         ARB_RESP: begin
            rsp_valid[win_q] = 1'b1;
            state_d          = ARB_IDLE;
         end

         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // State, round-robin pointer and datapath latches; reset drops any in-flight job
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ARB_IDLE;
         rr_ptr_q <= '0;
         win_q    <= '0;
         hin_q    <= '0;
         block_q  <= '0;
         hash_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         win_q    <= win_d;
         hin_q    <= hin_d;
         block_q  <= block_d;
         hash_q   <= hash_d;
      end
   end

`ifdef SHA_ARB_WDOG_EN
   // Watchdog counter and timeout flag
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign rsp_err = err_q;
`else
   assign core_abort = 1'b0;
   assign rsp_err    = 1'b0;
`endif

   assign core_hin   = hin_q;
   assign core_block = block_q;
   assign rsp_hash   = hash_q;
   assign busy       = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_sha256_core_arbiter.sv
// Scoreboarded bench for sha256_core_arbiter with a behavioural compression-core stand-in.
// Latency of the stand-in core is set per job through core_lat (0 = never completes).
// Build with SHA_ARB_WDOG_EN defined to exercise the watchdog paths.
module tb_sha256_core_arbiter;
   import sha256_pkg::*;

   localparam int NUM_REQ     = 4;
   localparam int TIMEOUT_CYC = 128;

   localparam hash_t ABC_DIGEST =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam block_t ABC_BLOCK = {32'h61626380, {14{32'h00000000}}, 32'h00000018};

   logic                   clk;
   logic                   reset;
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ*256-1:0] req_hin;
   logic [NUM_REQ*512-1:0] req_block;
   logic                   core_start;
   logic [255:0]           core_hin;
   logic [511:0]           core_block;
   logic                   core_done;
   logic [255:0]           core_hout;
   logic                   core_abort;
   logic [NUM_REQ-1:0]     rsp_valid;
   logic [255:0]           rsp_hash;
   logic                   rsp_err;
   logic                   busy;

   hash_t  hin_v [NUM_REQ];
   block_t blk_v [NUM_REQ];

   assign req_hin   = {hin_v[3], hin_v[2], hin_v[1], hin_v[0]};
   assign req_block = {blk_v[3], blk_v[2], blk_v[1], blk_v[0]};

   sha256_core_arbiter #(
      .NUM_REQ     (NUM_REQ),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_hin    (req_hin),
      .req_block  (req_block),
      .core_start (core_start),
      .core_hin   (core_hin),
      .core_block (core_block),
      .core_done  (core_done),
      .core_hout  (core_hout),
      .core_abort (core_abort),
      .rsp_valid  (rsp_valid),
      .rsp_hash   (rsp_hash),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   typedef struct {
      int     idx;
      hash_t  hin;
      block_t blk;
   } gnt_t;

   typedef struct {
      int    idx;
      hash_t hash;
      logic  err;
   } rsp_t;

   gnt_t gnt_q [$];
   gnt_t start_q [$];
   rsp_t rsp_q [$];

   int n_chk       = 0;
   int n_pass      = 0;
   int cyc         = 0;
   int last_start  = 0;
   int n_rdy       = 0;
   int n_start     = 0;
   int n_abort     = 0;
   int exp_abort   = 0;
   int core_lat    = 5;
   bit abort_allow = 1'b0;

   logic [NUM_REQ-1:0] prev_rdy = '0;
   logic [NUM_REQ-1:0] prev_rsp = '0;
   logic               prev_start = 1'b0;
   gnt_t               mon_g;
   gnt_t               mon_s;
   rsp_t               mon_r;

   // Stand-in digest: the real SHA-256 result for H0/"abc", a simple mix otherwise
   function automatic hash_t core_fn(hash_t h, block_t b);
      if (h == h0_hash() && b == ABC_BLOCK) begin
         return ABC_DIGEST;
      end
      return h ^ b[511:256] ^ {b[127:0], b[255:128]};
   endfunction

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_job(input int i, input hash_t h, input logic err);
      gnt_t g;
      rsp_t r;
      g.idx  = i;
      g.hin  = hin_v[i];
      g.blk  = blk_v[i];
      r.idx  = i;
      r.hash = h;
      r.err  = err;
      gnt_q.push_back(g);
      rsp_q.push_back(r);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Requester i keeps asking until it has been granted n[i] times; returns once idle again
   task automatic run_jobs(input int n0, input int n1, input int n2, input int n3, input int budget);
      int                 left [NUM_REQ];
      int                 t;
      logic [NUM_REQ-1:0] rdy;
      left = '{n0, n1, n2, n3};
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i] = (left[i] > 0);
      end
      t = 0;
      while ((req_valid != '0 || busy) && t < budget) begin
         @(negedge clk);
         rdy = req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (rdy[i]) begin
               left[i]--;
               if (left[i] <= 0) req_valid[i] = 1'b0;
            end
         end
         t++;
      end
      check("run_jobs_in_budget", (t < budget), 1);
      req_valid = '0;
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural compression core: captures the job on core_start, answers after core_lat cycles
   initial begin
      int     m_lat;
      hash_t  m_h;
      block_t m_b;
      core_done = 1'b0;
      core_hout = '0;
      forever begin
         @(negedge clk);
         if (core_start === 1'b1 && reset === 1'b0) begin
            m_lat = core_lat;
            m_h   = core_hin;
            m_b   = core_block;
            if (m_lat > 0) begin
               repeat (m_lat) @(posedge clk);
               #1;
               core_done = 1'b1;
               core_hout = core_fn(m_h, m_b);
               @(posedge clk);
               #1;
               core_done = 1'b0;
               core_hout = '0;
            end
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents a grant, a start, an abort or a response
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (req_ready != '0) begin
            n_rdy++;
            check("req_ready_one_cycle", prev_rdy, 0);
            if (gnt_q.size() == 0) begin
               check("unexpected_req_ready", req_ready, 0);
            end else begin
               mon_g = gnt_q.pop_front();
               check("grant_onehot", req_ready, 4'b0001 << mon_g.idx);
               start_q.push_back(mon_g);
            end
         end
         if (core_start === 1'b1) begin
            n_start++;
            last_start = cyc;
            check("core_start_one_cycle", prev_start, 0);
            if (start_q.size() == 0) begin
               check("unexpected_core_start", core_start, 0);
            end else begin
               mon_s = start_q.pop_front();
               check("core_hin", core_hin, mon_s.hin);
               check("core_block", core_block, mon_s.blk);
            end
         end
         if (core_abort === 1'b1) begin
            n_abort++;
            check("abort_allowed", abort_allow, 1);
            check("abort_cycle_after_start", cyc - last_start, TIMEOUT_CYC + 1);
         end
         if (rsp_valid != '0) begin
            check("rsp_valid_one_cycle", prev_rsp, 0);
            if (rsp_q.size() == 0) begin
               check("unexpected_rsp_valid", rsp_valid, 0);
            end else begin
               mon_r = rsp_q.pop_front();
               check("rsp_valid_onehot", rsp_valid, 4'b0001 << mon_r.idx);
               check("rsp_hash", rsp_hash, mon_r.hash);
               check("rsp_err", rsp_err, mon_r.err);
            end
         end
      end
      prev_rdy   = req_ready;
      prev_rsp   = rsp_valid;
      prev_start = core_start;
   end

   initial begin
      int   rdy_before;
      int   start_before;
      int   t;
      logic got;
      gnt_t g;

      reset     = 1'b1;
      req_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         hin_v[i] = {8{32'h01010101 * 32'(i + 1)}};
         blk_v[i] = {{8{32'ha5a50000 + 32'(i)}}, {8{32'h0f0f0000 + 32'(i * 16)}}};
      end
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_core_start", core_start, 0);
      check("rst_core_hin", core_hin, 0);
      check("rst_core_block", core_block, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_hash", rsp_hash, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_core_abort", core_abort, 0);
      check("rst_busy", busy, 0);

      // Single request: H0 and padded "abc" on requester 2
      hin_v[2] = h0_hash();
      blk_v[2] = ABC_BLOCK;
      core_lat = 64;
      expect_job(2, ABC_DIGEST, 1'b0);
      run_jobs(0, 0, 1, 0, 200);

      // All four requesting from rr_ptr=0: order 0,1,2,3,0
      do_reset();
      hin_v[2] = {8{32'h03030303}};
      blk_v[2] = {{8{32'ha5a50002}}, {8{32'h0f0f0020}}};
      core_lat = 5;
      expect_job(0, core_fn(hin_v[0], blk_v[0]), 1'b0);
      expect_job(1, core_fn(hin_v[1], blk_v[1]), 1'b0);
      expect_job(2, core_fn(hin_v[2], blk_v[2]), 1'b0);
      expect_job(3, core_fn(hin_v[3], blk_v[3]), 1'b0);
      expect_job(0, core_fn(hin_v[0], blk_v[0]), 1'b0);
      run_jobs(2, 1, 1, 1, 200);

      // Request withdrawn before GRANT
      rdy_before   = n_rdy;
      start_before = n_start;
      @(negedge clk);
      req_valid[1] = 1'b1;
      @(posedge clk);
      #1 req_valid[1] = 1'b0;
      @(negedge clk);
      check("withdraw_in_grant_busy", busy, 1);
      repeat (3) @(negedge clk);
      check("withdraw_back_idle", busy, 0);
      check("withdraw_no_req_ready", n_rdy, rdy_before);
      check("withdraw_no_core_start", n_start, start_before);

      // Reset mid-WAIT, stray core_done afterwards, then normal service from rr_ptr=0
      core_lat = 50;
      g.idx = 1;
      g.hin = hin_v[1];
      g.blk = blk_v[1];
      gnt_q.push_back(g);
      req_valid[1] = 1'b1;
      got = 1'b0;
      t   = 0;
      while (!got && t < 10) begin
         @(negedge clk);
         got = req_ready[1];
         t++;
      end
      @(posedge clk);
      #1 req_valid[1] = 1'b0;
      check("rstwait_req_granted", got, 1);
      repeat (10) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rstwait_busy", busy, 0);
      check("rstwait_core_hin", core_hin, 0);
      check("rstwait_core_block", core_block, 0);
      check("rstwait_rsp_valid", rsp_valid, 0);
      check("rstwait_rsp_hash", rsp_hash, 0);
      check("rstwait_core_start", core_start, 0);
      repeat (60) @(negedge clk);
      check("rstwait_stray_done_ignored", busy, 0);
      core_lat = 3;
      expect_job(1, core_fn(hin_v[1], blk_v[1]), 1'b0);
      expect_job(3, core_fn(hin_v[3], blk_v[3]), 1'b0);
      run_jobs(0, 1, 0, 1, 100);

`ifdef SHA_ARB_WDOG_EN
      // Core never completes: abort in the timeout cycle, error response with zero hash
      core_lat    = 0;
      abort_allow = 1'b1;
      exp_abort   = 1;
      expect_job(0, '0, 1'b1);
      run_jobs(1, 0, 0, 0, 400);
      abort_allow = 1'b0;

      // Completion lands in the timeout cycle: completion wins, no abort
      core_lat = TIMEOUT_CYC + 1;
      expect_job(3, core_fn(hin_v[3], blk_v[3]), 1'b0);
      run_jobs(0, 0, 0, 1, 400);
`else
      // No watchdog: a very slow core still completes normally
      core_lat = 1000;
      expect_job(0, core_fn(hin_v[0], blk_v[0]), 1'b0);
      run_jobs(1, 0, 0, 0, 1300);
`endif

      repeat (5) @(negedge clk);
      check("grant_queue_drained", gnt_q.size(), 0);
      check("start_queue_drained", start_q.size(), 0);
      check("rsp_queue_drained", rsp_q.size(), 0);
      check("abort_count", n_abort, exp_abort);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sha256_core_arbiter.md
# sha256_core_arbiter

Round-robin arbiter and sequencer sharing one SHA-256 compression core among NUM_REQ requesters (e.g. per-nonce hash lanes, first/second-block hashers). It latches a winning request's chaining value and 512-bit block, starts the core, waits for completion, and returns the digest to the winner. Sits between the bitcoin hash controllers and a single compression datapath.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- TIMEOUT_CYC, 128: watchdog limit in cycles, only used with SHA_ARB_WDOG_EN
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester job request
- req_ready  out  NUM_REQ  one-hot accept pulse to the winner
- req_hin  in  NUM_REQ×256  per-requester chaining value {h0..h7}, h0 in MSBs
- req_block  in  NUM_REQ×512  per-requester message block {w0..w15}, w0 in MSBs
- core_start  out  1  one-cycle start pulse to the core
- core_hin  out  256  latched chaining value
- core_block  out  512  latched block
- core_done  in  1  one-cycle completion pulse from the core
- core_hout  in  256  digest, valid with core_done
- core_abort  out  1  kill in-flight job (SHA_ARB_WDOG_EN only, else tied 0)
- rsp_valid  out  NUM_REQ  one-hot one-cycle result pulse
- rsp_hash  out  256  digest, valid with rsp_valid
- rsp_err  out  1  timeout flag, valid with rsp_valid
- busy  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, GRANT, START, WAIT, RESP.
- IDLE: when any req_valid is high, go to GRANT; otherwise stay.
- GRANT: choose the winner by round-robin.
  - Search starts at rr_ptr and wraps modulo NUM_REQ. The first requester with req_valid high wins.
  - Latch the winner index, req_hin and req_block. Pulse req_ready[winner] for this cycle only.
  - Set rr_ptr to (winner+1) mod NUM_REQ.
  - If no req_valid is high in this cycle (request withdrawn), return to IDLE with no pulse.
- START: assert core_start for one cycle, then go to WAIT.
- WAIT: on core_done, latch core_hout into rsp_hash and clear rsp_err, then go to RESP.
- RESP: pulse rsp_valid[winner] for one cycle, then go to IDLE.
- core_done outside WAIT is ignored. This covers stale completions after reset or abort.
- Requesters hold req_valid, req_hin and req_block stable until req_ready. Data is sampled only in GRANT.
- A winner may re-request immediately. Round-robin guarantees every waiting requester is served within NUM_REQ jobs.
- Reset:
  - All outputs go to 0, rr_ptr goes to 0, state goes to IDLE.
  - Reset during WAIT drops the job with no rsp_valid.
- Widths: the watchdog counter is $clog2(TIMEOUT_CYC+1) bits and saturates. The winner index is $clog2(NUM_REQ) bits.

## Timing
- Request to req_ready: 1 cycle when arriving in IDLE (the IDLE→GRANT cycle). req_ready is asserted during GRANT.
- req_ready to core_start: 1 cycle.
- core_done to rsp_valid: 1 cycle (WAIT→RESP registered).
- Back-to-back: the minimum per-job overhead outside core latency is 4 cycles (IDLE, GRANT, START, RESP).
- core_start, req_ready and rsp_valid are never high for more than one cycle.
- core_hin and core_block hold stable from START until leaving WAIT.

## Configuration
- SHA_ARB_WDOG_EN defined:
  - WAIT counts cycles from entry.
  - If the count reaches TIMEOUT_CYC without core_done, pulse core_abort for one cycle, set rsp_err=1 and rsp_hash=0, and go to RESP.
  - If core_done and the timeout occur in the same cycle, core_done wins: rsp_err=0 and no abort.
- SHA_ARB_WDOG_EN undefined: no counter, core_abort is constant 0, rsp_err is constant 0, and WAIT waits indefinitely.

## Structure
- Shared package sha256_pkg holds:
  - the SHA-256 initial hash constant array H0[8]
  - typedefs hash_t (256-bit) and block_t (512-bit)
  - the FSM state enum typedef
- One sub-module, rr_arbiter: a combinational round-robin pick from req_valid and rr_ptr, producing a one-hot grant and an index. It can be reused by other shared-resource controllers.
- All state, the datapath latches and the counters live in sha256_core_arbiter.

## Test plan
- Single request: req_valid[2]=1 with hin=H0 and block = padded "abc"; core model returns after 64 cycles → exactly one req_ready[2] pulse, core_block equal to the block, rsp_valid[2] with rsp_hash=ba7816bf…f20015ad and rsp_err=0.
- All four requesters asserted continuously, rr_ptr=0 after reset → grant order 0,1,2,3,0. Each job's rsp_hash matches that requester's block.
- Request withdrawn: req_valid[1] pulses for one cycle in IDLE and drops before GRANT → no req_ready, no core_start, back to IDLE.
- Reset asserted mid-WAIT, then a stray core_done after reset → no rsp_valid, all outputs 0, busy=0. A following request is served normally from rr_ptr=0.
- With SHA_ARB_WDOG_EN, core never completes, TIMEOUT_CYC=128 → core_abort 128 cycles after WAIT entry, then rsp_valid with rsp_err=1 and rsp_hash=0. In a second run, core_done in the timeout cycle gives rsp_err=0 and no abort.
- Without SHA_ARB_WDOG_EN, core completes after 1000 cycles → rsp_valid with rsp_err=0 and core_abort never asserted.
